multi_cdb_arbiter: RTL and testbench
====================================

Name: multi_cdb_arbiter

Overview:
- Parametrised successor to the single-lane CDB arbiter.
- Arbitrates completed functional-unit results onto NUM_CDB parallel common-data-bus lanes per cycle, using rotating round-robin priority.
- Returns a per-FU ack, and registers the broadcast (tag, data, source index) for the RS/ROB/map table.
- Sits between the ex stage FU outputs and all CDB consumers; supports squash.

Parameters:
NUM_REQ, 8, number of requesting functional units
NUM_CDB, 2, number of broadcast lanes per cycle (1 <= NUM_CDB <= NUM_REQ)
TAG_W, 5, ROB tag width
DATA_W, 32, result data width
IDX_W, $clog2(NUM_REQ), source index width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
squash  in  1  pipeline flush; kills this cycle's grants and pending broadcasts
req_valid  in  NUM_REQ  FU i has a finished result (done)
req_tag  in  NUM_REQ*TAG_W  ROB tag of FU i, slice i
req_data  in  NUM_REQ*DATA_W  result of FU i, slice i
ack  out  NUM_REQ  combinational grant to FU i this cycle; FU may drop/replace its result next cycle
cdb_valid  out  NUM_CDB  lane k broadcasting (registered)
cdb_tag  out  NUM_CDB*TAG_W  lane k tag (registered)
cdb_data  out  NUM_CDB*DATA_W  lane k value (registered)
cdb_src  out  NUM_CDB*IDX_W  lane k source FU index (registered)

Behaviour:
- State: rr_ptr (IDX_W bits), lane output registers. Reset: rr_ptr=0, cdb_valid=0, cdb_tag/data/src=0. ack=0 while reset is high.
- Search order each cycle: rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ (NUM_REQ need not be a power of two).
- Grant rule: the first min(NUM_CDB, popcount(req_valid)) valid requesters in search order are granted; ack[i]=1 for each; ack is combinational from req_valid and rr_ptr.
- Lane assignment: the j-th granted requester in search order drives lane j. Lanes j >= number of grants have valid=0; their tag/data/src hold their previous values.
- Latency: request granted in cycle t appears on the cdb_* outputs in cycle t+1. Each result is broadcast exactly once.
- Pointer update:
  - If >= 1 grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant: rr_ptr unchanged.
- Fairness: a continuously asserted request is acked within ceil(NUM_REQ/NUM_CDB) cycles.
- Request contract: FU holds req_valid/tag/data stable until acked. Deassertion before ack is legal and simply withdraws the request. Arbiter keeps no per-FU buffer.
- Squash (synchronous, higher priority than arbitration, lower than reset):
  - ack=0 in the squash cycle.
  - cdb_valid <= 0 at the next edge.
  - rr_ptr unchanged.
  - Results already on the CDB in the squash cycle still count as broadcast in that cycle.
- Reset mid-operation: same-edge clear of all state; in-flight grants are lost.
- Simultaneous reset and squash: reset wins. Result is identical either way.
- Tag collisions: not checked; duplicate tags are broadcast as-is.
- NUM_CDB == NUM_REQ: every valid request is granted every cycle; rr_ptr still updates per the rule above.

Test Plan:
(Parameters NUM_REQ=8, NUM_CDB=2.)
1. Reset then idle: reset=1 for 2 cycles, req_valid=0 -> ack=0, cdb_valid=00, rr_ptr=0 for all cycles.
2. Single request: req_valid=8'h04, tag=3, data=32'h5 -> ack=8'h04 in that cycle; next cycle cdb_valid=01, lane0 tag=3, data=5, src=2; rr_ptr=3.
3. Full contention: all 8 FUs request and hold until acked, starting rr_ptr=0 -> acks 0x03, 0x0C, 0x30, 0xC0 on successive cycles; each tag broadcast exactly once; rr_ptr wraps to 0.
4. Wrap-around: rr_ptr=7, req_valid=8'h81 -> ack=8'h81; next cycle lane0 src=7, lane1 src=0; rr_ptr=1.
5. Squash: req_valid=8'h11 with squash=1 -> ack=0; next cycle cdb_valid=00; rr_ptr unchanged. On the following cycle without squash, both requests are granted normally.
6. Randomized: 200 cycles of random req_valid with hold-until-ack -> scoreboard confirms every request is acked once and broadcast once, one cycle later; max wait <= 4 cycles.

Source files
------------

// File: rtl/multi_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cdb_arbiter
//  Purpose  : Round-robin arbiter that moves up to NUM_CDB finished
//             functional-unit results per cycle onto parallel common-data-bus
//             lanes. It returns a combinational ack to each granted FU and
//             registers the broadcast (tag, data, source index) for the
//             RS/ROB/map table consumers.
//  Ports    : clock, reset (sync, active-high), squash (kills grants)
//             req_valid/req_tag/req_data : per-FU results, slice i = FU i
//             ack                        : per-FU grant, combinational
//             cdb_valid/tag/data/src     : per-lane broadcast, registered
//  Revision : 1.0 - initial release
// ============================================================================
module multi_cdb_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  output logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic [NUM_CDB*IDX_W-1:0]  cdb_src
);

  // One extra bit so rr_ptr + offset can exceed NUM_REQ before wrapping;
  // NUM_REQ need not be a power of two.
  localparam logic [IDX_W:0]   c_num_req  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]          r_rr_ptr;
  logic [NUM_CDB-1:0]        r_cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  r_cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] r_cdb_data;
  logic [NUM_CDB*IDX_W-1:0]  r_cdb_src;

  logic [NUM_REQ-1:0] w_ack;
  logic [NUM_CDB-1:0] w_lane_valid;
  logic [IDX_W-1:0]   w_lane_src  [NUM_CDB];
  logic [TAG_W-1:0]   w_lane_tag  [NUM_CDB];
  logic [DATA_W-1:0]  w_lane_data [NUM_CDB];
  logic [IDX_W:0]     w_pos;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_last;
  logic [IDX_W-1:0]   w_ptr_next;
  int                 w_cnt;

  // Walk the requesters in priority order starting at rr_ptr. The j-th valid
  // requester found is granted and placed on lane j until lanes run out.
  always_comb begin
    w_ack        = '0;
    w_lane_valid = '0;
    w_last       = r_rr_ptr;
    w_pos        = '0;
    w_idx        = '0;
    w_cnt        = 0;
    for (int j = 0; j < NUM_CDB; j++) begin
      w_lane_src[j] = '0;
    end
    if (!reset && !squash) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
        if (w_pos >= c_num_req) begin
          w_pos = w_pos - c_num_req;
        end
        w_idx = w_pos[IDX_W-1:0];
        if (req_valid[w_idx] && (w_cnt < NUM_CDB)) begin
          w_ack[w_idx] = 1'b1;
          for (int j = 0; j < NUM_CDB; j++) begin
            if (j == w_cnt) begin
              w_lane_valid[j] = 1'b1;
              w_lane_src[j]   = w_idx;
            end
          end
          w_cnt  = w_cnt + 1;
          w_last = w_idx;
        end
      end
    end
  end

  // Per-lane payload mux keyed by the granted source index.
  always_comb begin
    for (int j = 0; j < NUM_CDB; j++) begin
      w_lane_tag[j]  = '0;
      w_lane_data[j] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_lane_src[j] == IDX_W'(i)) begin
          w_lane_tag[j]  = req_tag[i*TAG_W +: TAG_W];
          w_lane_data[j] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Priority moves just past the last requester served this cycle.
  assign w_ptr_next = (w_last == c_last_idx) ? '0 : w_last + IDX_W'(1);

  // A squashed cycle produces no grants, so the lanes simply go idle and the
  // pointer holds; idle lanes keep their old payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= '0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
    end else begin
      r_cdb_valid <= w_lane_valid;
      for (int j = 0; j < NUM_CDB; j++) begin
        if (w_lane_valid[j]) begin
          r_cdb_tag[j*TAG_W +: TAG_W]    <= w_lane_tag[j];
          r_cdb_data[j*DATA_W +: DATA_W] <= w_lane_data[j];
          r_cdb_src[j*IDX_W +: IDX_W]    <= w_lane_src[j];
        end
      end
      if (|w_ack) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign ack       = w_ack;
  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_multi_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_cdb_arbiter
//  Purpose  : Self-checking bench for multi_cdb_arbiter (NUM_REQ=8,
//             NUM_CDB=2). Directed scenarios plus a randomized run compared
//             against a queue-based priority model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_cdb_arbiter;
  localparam int N  = 8;
  localparam int C  = 2;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int IW = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            squash;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [C-1:0]    cdb_valid;
  logic [C*TW-1:0] cdb_tag;
  logic [C*DW-1:0] cdb_data;
  logic [C*IW-1:0] cdb_src;

  multi_cdb_arbiter #(
    .NUM_REQ(N), .NUM_CDB(C), .TAG_W(TW), .DATA_W(DW), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .ack(ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [TW-1:0] tb_tag  [N];
  logic [DW-1:0] tb_data [N];

  // Reference model state: priority pointer and expected lane registers.
  int              m_ptr;
  logic [N-1:0]    e_ack;
  logic [C-1:0]    e_valid;
  logic [C*TW-1:0] e_tag;
  logic [C*DW-1:0] e_data;
  logic [C*IW-1:0] e_src;

  task automatic model_reset();
    m_ptr = 0; e_ack = '0; e_valid = '0; e_tag = '0; e_data = '0; e_src = '0;
  endtask

  // Build the search order as a list, keep the valid entries, take the first C.
  task automatic predict(input logic [N-1:0] rv, input logic sq);
    int order[$];
    int granted[$];
    e_ack   = '0;
    e_valid = '0;
    if (!sq) begin
      for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
      foreach (order[k]) if (rv[order[k]] && granted.size() < C) granted.push_back(order[k]);
      foreach (granted[j]) begin
        e_ack[granted[j]]    = 1'b1;
        e_valid[j]           = 1'b1;
        e_src[j*IW +: IW]    = IW'(granted[j]);
        e_tag[j*TW +: TW]    = tb_tag[granted[j]];
        e_data[j*DW +: DW]   = tb_data[granted[j]];
      end
      if (granted.size() > 0) m_ptr = (granted[granted.size()-1] + 1) % N;
    end
  endtask

  task automatic drive(input logic [N-1:0] rv, input logic sq);
    @(negedge clock);
    req_valid = rv;
    squash    = sq;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tb_tag[i];
      req_data[i*DW +: DW] = tb_data[i];
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; squash = 1'b0; req_valid = '0;
    tick();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive((c == 1) ? 8'hFF : 8'h00, 1'b0);
      checks++; if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h want 00", ack); end
      tick();
      checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_cdb_valid: got %b want 00", cdb_valid); end
      checks++; if (cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0) begin
        errors++; $display("FAIL reset_payload: tag %h data %h src %h want all zero", cdb_tag, cdb_data, cdb_src);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    drive(8'h00, 1'b0);
    predict(8'h00, 1'b0);
    checks++; if (ack !== 8'h00) begin errors++; $display("FAIL idle_ack: got %h want 00", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL idle_cdb_valid: got %b want 00", cdb_valid); end
  endtask

  task automatic test_single();
    tb_tag[2] = 5'd3; tb_data[2] = 32'h5;
    drive(8'h04, 1'b0); predict(8'h04, 1'b0);
    checks++; if (ack !== 8'h04) begin errors++; $display("FAIL single_ack: got %h want 04", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b01 || cdb_tag[4:0] !== 5'd3 || cdb_data[31:0] !== 32'h5 || cdb_src[2:0] !== 3'd2) begin
      errors++; $display("FAIL single_lane0: valid %b tag %0d data %h src %0d want 01 3 5 2", cdb_valid, cdb_tag[4:0], cdb_data[31:0], cdb_src[2:0]);
    end
    // Pointer now at 3: FU3 wins lane 0 ahead of FU0.
    drive(8'h0F, 1'b0); predict(8'h0F, 1'b0);
    checks++; if (ack !== 8'h09) begin errors++; $display("FAIL single_ptr_ack: got %h want 09", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b11 || cdb_src !== {3'd0, 3'd3}) begin
      errors++; $display("FAIL single_ptr_lanes: valid %b src %h want 11 %h", cdb_valid, cdb_src, {3'd0, 3'd3});
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] pending;
    logic [N-1:0] exp_seq [4];
    int           seen [N];
    exp_seq[0] = 8'h03; exp_seq[1] = 8'h0C; exp_seq[2] = 8'h30; exp_seq[3] = 8'hC0;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      tb_tag[i] = TW'(i + 8); tb_data[i] = $urandom; seen[i] = 0;
    end
    pending = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      drive(pending, 1'b0); predict(pending, 1'b0);
      checks++; if (ack !== exp_seq[c]) begin errors++; $display("FAIL contention_ack%0d: got %h want %h", c, ack, exp_seq[c]); end
      pending = pending & ~ack;
      tick();
      for (int j = 0; j < C; j++) if (cdb_valid[j]) begin
        seen[cdb_src[j*IW +: IW]]++;
        checks++; if (cdb_tag[j*TW +: TW] !== tb_tag[cdb_src[j*IW +: IW]]) begin
          errors++; $display("FAIL contention_tag: lane %0d got %h want %h", j, cdb_tag[j*TW +: TW], tb_tag[cdb_src[j*IW +: IW]]);
        end
      end
    end
    drive(8'h00, 1'b0); predict(8'h00, 1'b0);
    tick();
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL contention_drain: got %b want 00", cdb_valid); end
    for (int i = 0; i < N; i++) begin
      checks++; if (seen[i] != 1) begin errors++; $display("FAIL contention_once: FU%0d broadcast %0d times want 1", i, seen[i]); end
    end
    // Only pointer 0 puts FU0 ahead of FU7.
    drive(8'h81, 1'b0); predict(8'h81, 1'b0);
    tick();
    checks++; if (cdb_src !== {3'd7, 3'd0}) begin errors++; $display("FAIL contention_wrap_ptr: src %h want %h", cdb_src, {3'd7, 3'd0}); end
  endtask

  task automatic test_wrap();
    drive(8'h40, 1'b0); predict(8'h40, 1'b0);
    tick();
    drive(8'h81, 1'b0); predict(8'h81, 1'b0);
    checks++; if (ack !== 8'h81) begin errors++; $display("FAIL wrap_ack: got %h want 81", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b11 || cdb_src !== {3'd0, 3'd7}) begin
      errors++; $display("FAIL wrap_lanes: valid %b src %h want 11 %h", cdb_valid, cdb_src, {3'd0, 3'd7});
    end
    // Pointer now at 1: FU1 precedes FU0.
    drive(8'h03, 1'b0); predict(8'h03, 1'b0);
    tick();
    checks++; if (cdb_src !== {3'd0, 3'd1}) begin errors++; $display("FAIL wrap_ptr1: src %h want %h", cdb_src, {3'd0, 3'd1}); end
  endtask

  task automatic test_squash();
    drive(8'h04, 1'b0); predict(8'h04, 1'b0);
    tick();
    drive(8'h11, 1'b1); predict(8'h11, 1'b1);
    checks++; if (ack !== 8'h00) begin errors++; $display("FAIL squash_ack: got %h want 00", ack); end
    checks++; if (cdb_valid !== 2'b01 || cdb_src[2:0] !== 3'd2) begin
      errors++; $display("FAIL squash_inflight: valid %b src %0d want 01 2", cdb_valid, cdb_src[2:0]);
    end
    tick();
    checks++; if (cdb_valid !== 2'b00 || cdb_src[2:0] !== 3'd2) begin
      errors++; $display("FAIL squash_kill: valid %b src %0d want 00 2", cdb_valid, cdb_src[2:0]);
    end
    // Pointer held at 3 through the squash: FU4 precedes FU0.
    drive(8'h11, 1'b0); predict(8'h11, 1'b0);
    checks++; if (ack !== 8'h11) begin errors++; $display("FAIL squash_regrant_ack: got %h want 11", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b11 || cdb_src !== {3'd0, 3'd4}) begin
      errors++; $display("FAIL squash_regrant_lanes: valid %b src %h want 11 %h", cdb_valid, cdb_src, {3'd0, 3'd4});
    end
    // Reset together with squash: reset clears everything.
    @(negedge clock);
    reset = 1'b1; squash = 1'b1; req_valid = 8'hFF;
    #1;
    checks++; if (ack !== 8'h00) begin errors++; $display("FAIL rst_squash_ack: got %h want 00", ack); end
    tick();
    checks++; if (cdb_valid !== 2'b00 || cdb_src !== '0 || cdb_tag !== '0) begin
      errors++; $display("FAIL rst_squash_clear: valid %b src %h tag %h want zero", cdb_valid, cdb_src, cdb_tag);
    end
    @(negedge clock);
    reset = 1'b0; squash = 1'b0; req_valid = '0;
    model_reset();
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    int           waitc [N];
    int           acked;
    int           bcast;
    int           max_wait;
    pending = '0; acked = 0; bcast = 0; max_wait = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < N; i++) if (!pending[i] && $urandom_range(0, 2) == 0) begin
        pending[i] = 1'b1; tb_tag[i] = TW'($urandom); tb_data[i] = $urandom; waitc[i] = 0;
      end
      drive(pending, 1'b0); predict(pending, 1'b0);
      checks++; if (ack !== e_ack) begin errors++; $display("FAIL rand_ack c%0d: got %h want %h", c, ack, e_ack); end
      for (int i = 0; i < N; i++) if (pending[i]) begin
        waitc[i]++;
        if (ack[i]) begin
          pending[i] = 1'b0; acked++;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
      end
      tick();
      bcast += $countones(cdb_valid);
      checks++; if (cdb_valid !== e_valid || cdb_src !== e_src || cdb_tag !== e_tag || cdb_data !== e_data) begin
        errors++; $display("FAIL rand_cdb c%0d: valid %b src %h tag %h got/want valid %b src %h tag %h", c, cdb_valid, cdb_src, cdb_tag, e_valid, e_src, e_tag);
      end
    end
    checks++; if (max_wait > 4) begin errors++; $display("FAIL rand_max_wait: got %0d want <= 4", max_wait); end
    checks++; if (bcast != acked) begin errors++; $display("FAIL rand_once: broadcasts %0d want %0d", bcast, acked); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; squash = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin tb_tag[i] = '0; tb_data[i] = '0; end
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_squash();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
